// File: rtl/dcpu16_alux_if.sv
// Request/result bundle between the DCPU16 sequencer and the multi-cycle ALU.
// Parameter: DW -- datapath width.
// The master (sequencer) side drives:
//   ena          -- global clock-enable
//   stb, opc     -- operation request and opcode
//   regA, regB   -- operands
// The slave (ALU) side returns:
//   busy         -- divider running
//   ack          -- completion pulse
//   regR, regO   -- result and overflow registers
//   CC           -- skip condition
//   rwd          -- register write data (mirror of regR)
interface dcpu16_alux_if #(
  parameter int unsigned DW = 16
);
  logic          ena;
  logic          stb;
  logic [3:0]    opc;
  logic [DW-1:0] regA;
  logic [DW-1:0] regB;
  logic          busy;
  logic          ack;
  logic [DW-1:0] regR;
  logic [DW-1:0] regO;
  logic          CC;
  logic [DW-1:0] rwd;

  modport master (
    output ena, stb, opc, regA, regB,
    input  busy, ack, regR, regO, CC, rwd
  );

  modport slave (
    input  ena, stb, opc, regA, regB,
    output busy, ack, regR, regO, CC, rwd
  );
endinterface

// File: rtl/dcpu16_alux.sv
// Multi-cycle ALU for the DCPU16 execute stage.
//
// All basic opcodes complete on the accept edge, except DIV/MOD. Those run on
// an iterative restoring divider that divides {a, DW'b0} by b, so the
// quotient delivers both a/b (upper half) and the fractional part
// ((a<<DW)/b, lower half) in one pass. The partial remainder after the first
// DW quotient bits is a%b.
//
// Ports:
//   clk  -- clock
//   rst  -- synchronous active-high reset; aborts a running divide, no ack
//   bus  -- dcpu16_alux_if slave:
//     ena         -- clock-enable; low freezes every register
//     stb/opc     -- request, accepted when ena & stb & ~busy
//     regA/regB   -- operands, consumed on the accept edge
//     busy        -- divider running, stb ignored
//     ack         -- one-enabled-cycle completion pulse
//     regR/regO   -- result / overflow registers
//     CC          -- skip condition
//     rwd         -- write data, equal to regR
//
// Build option: define DCPU16_ALU_RADIX4_EN to retire two quotient bits per
// enabled cycle (DIV/MOD latency DW+1 instead of 2*DW+1). DW must be even in
// that build. Results are identical in both builds.
module dcpu16_alux #(
  parameter int unsigned DW = 16
) (
  input logic          clk,
  input logic          rst,
  dcpu16_alux_if.slave bus
);

  localparam int unsigned CNTW = $clog2(2 * DW) + 1;

`ifdef DCPU16_ALU_RADIX4_EN
  localparam int unsigned Iters = DW;
`else
  localparam int unsigned Iters = 2 * DW;
`endif
  // Counter value once the first DW quotient bits are done.
  localparam int unsigned ModIters = Iters / 2;

  // Shift amounts at or beyond this clear both halves.
  localparam logic [DW-1:0] ShLimit = DW'(2 * DW);

  localparam logic [3:0] OpJsr = 4'h0;
  localparam logic [3:0] OpSet = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpMul = 4'h4;
  localparam logic [3:0] OpDiv = 4'h5;
  localparam logic [3:0] OpMod = 4'h6;
  localparam logic [3:0] OpShl = 4'h7;
  localparam logic [3:0] OpShr = 4'h8;
  localparam logic [3:0] OpAnd = 4'h9;
  localparam logic [3:0] OpBor = 4'hA;
  localparam logic [3:0] OpXor = 4'hB;
  localparam logic [3:0] OpIfe = 4'hC;
  localparam logic [3:0] OpIfn = 4'hD;
  localparam logic [3:0] OpIfg = 4'hE;
  localparam logic [3:0] OpIfb = 4'hF;

  typedef enum logic [1:0] {StIdle, StDiv, StFin} state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2*DW-1:0] dvd_q, dvd_d;    // dividend, consumed MSB first
  logic [2*DW-1:0] quo_q, quo_d;    // quotient, shifted in LSB first
  logic [DW-1:0]   rem_q, rem_d;    // partial remainder, always < divisor
  logic [DW-1:0]   dsr_q, dsr_d;    // latched divisor
  logic [DW-1:0]   mod_q, mod_d;    // remainder snapshot = a%b
  logic            is_mod_q, is_mod_d;
  logic            bzero_q, bzero_d;
  logic [DW-1:0]   r_q, r_d;
  logic [DW-1:0]   o_q, o_d;
  logic            cc_q, cc_d;
  logic            ack_q, ack_d;

  logic [DW-1:0]   a;
  logic [DW-1:0]   b;

  assign a = bus.regA;
  assign b = bus.regB;

  // One restoring step: returns {quotient bit, new remainder}.
  function automatic logic [DW:0] div_step(input logic [DW-1:0] rem,
                                           input logic          bit_in,
                                           input logic [DW-1:0] d);
    logic [DW:0] sh;
    logic [DW:0] sub;
    sh  = {rem, bit_in};
    sub = sh - {1'b0, d};
    if (sh >= {1'b0, d}) begin
      return {1'b1, sub[DW-1:0]};
    end
    return {1'b0, sh[DW-1:0]};
  endfunction

  // Single-cycle datapath.
  logic [DW:0]     sum;
  logic [DW:0]     dif;
  logic [2*DW-1:0] prod;
  logic            sh_big;
  logic [2*DW-1:0] shl_w;
  logic [2*DW-1:0] shr_w;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign dif    = {1'b0, a} - {1'b0, b};
  assign prod   = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign sh_big = (b >= ShLimit);
  assign shl_w  = sh_big ? '0 : ({{DW{1'b0}}, a} << b);
  // Upper half is a>>b, lower half the bits shifted out.
  assign shr_w  = sh_big ? '0 : ({a, {DW{1'b0}}} >> b);

  // Divider iteration datapath.
  logic [DW:0]     st1;
  logic [DW-1:0]   rem_nx;
  logic [2*DW-1:0] dvd_nx;
  logic [2*DW-1:0] quo_nx;

  assign st1 = div_step(rem_q, dvd_q[2*DW-1], dsr_q);

`ifdef DCPU16_ALU_RADIX4_EN
  logic [DW:0] st2;

  assign st2    = div_step(st1[DW-1:0], dvd_q[2*DW-2], dsr_q);
  assign rem_nx = st2[DW-1:0];
  assign dvd_nx = {dvd_q[2*DW-3:0], 2'b00};
  assign quo_nx = {quo_q[2*DW-3:0], st1[DW], st2[DW]};
`else
  assign rem_nx = st1[DW-1:0];
  assign dvd_nx = {dvd_q[2*DW-2:0], 1'b0};
  assign quo_nx = {quo_q[2*DW-2:0], st1[DW]};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    mod_d    = mod_q;
    is_mod_d = is_mod_q;
    bzero_d  = bzero_q;
    r_d      = r_q;
    o_d      = o_q;
    cc_d     = cc_q;
    ack_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ena gating lives in the register process.
        if (bus.stb) begin
          cc_d  = 1'b1;
          ack_d = 1'b1;
          unique case (bus.opc)
            OpJsr, OpSet: r_d = b;
            OpAdd: begin
              r_d = sum[DW-1:0];
              o_d = {{(DW-1){1'b0}}, sum[DW]};
            end
            OpSub: begin
              r_d = dif[DW-1:0];
              o_d = {DW{dif[DW]}};
            end
            OpMul: {o_d, r_d} = prod;
            OpDiv, OpMod: begin
              ack_d    = 1'b0;
              is_mod_d = (bus.opc == OpMod);
              dvd_d    = {a, {DW{1'b0}}};
              dsr_d    = b;
              rem_d    = '0;
              quo_d    = '0;
              mod_d    = '0;
              cnt_d    = CNTW'(Iters);
              bzero_d  = (b == '0);
              state_d  = (b == '0) ? StFin : StDiv;
            end
            OpShl: {o_d, r_d} = shl_w;
            OpShr: begin
              r_d = shr_w[2*DW-1:DW];
              o_d = shr_w[DW-1:0];
            end
            OpAnd: r_d = a & b;
            OpBor: r_d = a | b;
            OpXor: r_d = a ^ b;
            OpIfe: cc_d = (a == b);
            OpIfn: cc_d = (a != b);
            OpIfg: cc_d = (a > b);
            OpIfb: cc_d = |(a & b);
            default: ;
          endcase
        end
      end

      StDiv: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_d == CNTW'(ModIters)) begin
          mod_d = rem_nx;
        end
        if (cnt_d == '0) begin
          state_d = StFin;
        end
      end

      StFin: begin
        state_d = StIdle;
        ack_d   = 1'b1;
        if (bzero_q) begin
          r_d = '0;
          if (!is_mod_q) begin
            o_d = '0;
          end
        end else if (is_mod_q) begin
          r_d = mod_q;
        end else begin
          {r_d, o_d} = quo_q;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      mod_q    <= '0;
      is_mod_q <= 1'b0;
      bzero_q  <= 1'b0;
      r_q      <= '0;
      o_q      <= '0;
      cc_q     <= 1'b0;
      ack_q    <= 1'b0;
    end else if (bus.ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      mod_q    <= mod_d;
      is_mod_q <= is_mod_d;
      bzero_q  <= bzero_d;
      r_q      <= r_d;
      o_q      <= o_d;
      cc_q     <= cc_d;
      ack_q    <= ack_d;
    end
  end

  // FIN still counts as busy, so the earliest new accept is after the ack.
  assign bus.busy = (state_q != StIdle);
  assign bus.ack  = ack_q;
  assign bus.regR = r_q;
  assign bus.regO = o_q;
  assign bus.CC   = cc_q;
  assign bus.rwd  = r_q;

endmodule
